spinv_game_sequencer: RTL
=========================

Name: spinv_game_sequencer

Overview:
Top-level game-phase controller for the Space Invaders datapath. It runs the phase FSM (idle, ready banner, play, hit pause, wave cleared, game over) and tracks lives and level. It derives a frame tick from Clk and issues per-frame update strobes for ship, aliens, player projectile and return fire, so the datapath advances at a controlled rate instead of every clock. It also issues clear pulses that re-initialise the field or remove in-flight shots.

Parameters:
FRAME_DIV, 1666667, Clk cycles per frame (100 MHz / 60 Hz); benches override with a small value
ALIEN_DIV_INIT, 4, frames per alien step at level 1
ALIEN_DIV_MIN, 1, fastest alien step rate, in frames
BANNER_FRAMES, 120, frames spent in the START, HIT and CLEARED pauses
LIVES, 3, lives granted at game start (1..3)

Ports:
Clk  in  1  system clock
reset  in  1  synchronous, active-high
start  in  1  debounced start button, level
player_hit  in  1  one-cycle pulse: return fire struck the ship
wave_cleared  in  1  level: all 15 aliens destroyed
invaders_landed  in  1  level: bottom alien row has passed the ship line
state  out  3  0 IDLE, 1 START, 2 PLAY, 3 HIT, 4 CLEARED, 5 OVER
frame_tick  out  1  one-cycle pulse, once per frame
ship_en  out  1  ship update strobe
alien_en  out  1  alien formation step strobe
proj_en  out  1  player projectile update strobe
fire_en  out  1  return-fire update strobe
field_clr  out  1  one-cycle pulse: re-init aliens, rows, score, ship, shots
shots_clr  out  1  one-cycle pulse: remove both projectiles only
lives  out  2  remaining lives
level  out  4  current wave, 1..15

Behaviour:
- Reset values: state=IDLE, lives=LIVES, level=1, every strobe and clear output 0. Frame, alien and banner counters reset to 0. The start edge register resets to 1, so a button held through reset does not start a game.
- Frame counter: free-running 0..FRAME_DIV-1 in every state. frame_tick=1 on the cycle the counter equals FRAME_DIV-1; the counter wraps to 0 on the next cycle.
- start_evt = start & ~start_q (rising edge). start_q is registered every cycle.
- Strobes are 0 in every state except PLAY. In PLAY:
  - ship_en = proj_en = frame_tick.
  - fire_en = frame_tick on even frames only (1-bit frame parity, toggles on each frame_tick, cleared on PLAY entry).
  - alien_en = frame_tick & (acnt == adiv-1). acnt increments on each frame_tick in PLAY and wraps to 0 after adiv-1. acnt is cleared on PLAY entry.
  - adiv = max(ALIEN_DIV_INIT-(level-1), ALIEN_DIV_MIN), computed unsigned with underflow guarded (never wraps to a large value).
- Banner counter: cleared on entry to START, HIT and CLEARED. Increments on frame_tick. The state exits on the frame_tick where bcnt == BANNER_FRAMES-1.
- FSM transitions, all registered:
  - IDLE: start_evt -> START with lives=LIVES, level=1.
  - START: banner done -> PLAY.
  - PLAY, priority order landed > hit > cleared:
    - invaders_landed -> OVER, lives=0.
    - player_hit and lives==1 -> OVER, lives=0.
    - player_hit and lives>1 -> HIT, lives-1.
    - wave_cleared -> CLEARED, level+1, saturating at 15.
  - HIT: banner done -> PLAY.
  - CLEARED: banner done -> START.
  - OVER: start_evt -> START with lives=LIVES, level=1.
- field_clr is asserted exactly on the first cycle in START, whatever the source state.
- shots_clr is asserted exactly on the first cycle in HIT.
- Clear and enable pulses never coincide.
- Inputs (player_hit, wave_cleared, invaders_landed) are ignored outside PLAY. start_evt is ignored outside IDLE and OVER.
- A player_hit that arrives on the same cycle as a PLAY-exit transition is consumed by the priority rule. It is never queued.
- Reset mid-operation returns to IDLE on the next edge regardless of state or counters.

Test Plan:
FRAME_DIV=4, BANNER_FRAMES=2, ALIEN_DIV_INIT=4, LIVES=3 for all scenarios.
1. Hold start high through reset release -> remains IDLE. Drop start, then pulse it -> START next cycle, field_clr=1 for 1 cycle, lives=3, level=1; PLAY after 2 frame_ticks.
2. PLAY for 8 frames -> ship_en 8 times, fire_en 4 times, alien_en 2 times, each exactly on a frame_tick cycle.
3. Pulse player_hit three times, each after returning to PLAY -> HIT with shots_clr, lives 2, then HIT with lives 1, then OVER with lives 0; all strobes 0 in OVER.
4. Assert wave_cleared in PLAY -> CLEARED, level=2, then START with field_clr; alien_en every 3 frames in the following PLAY. Repeat to level 5 -> alien_en every frame (ALIEN_DIV_MIN). Continue to level 15 -> level stays 15.
5. Assert invaders_landed and player_hit together in PLAY -> OVER, lives=0, no HIT and no shots_clr.
6. Assert reset in CLEARED mid-banner -> IDLE, lives=3, level=1, all outputs 0 next cycle.

Source files
------------

// File: rtl/spinv_game_sequencer_if.sv
// spinv_game_sequencer_if
//   Bundles the signals between the game-phase sequencer and the rest of the
//   Space Invaders datapath.
//
//   Game events into the sequencer:
//     start            debounced start button, level
//     player_hit       one-cycle pulse, return fire struck the ship
//     wave_cleared     level, all aliens of the wave destroyed
//     invaders_landed  level, bottom alien row passed the ship line
//   Sequencer outputs to the datapath:
//     state            phase code (0 IDLE .. 5 OVER); also the FSM debug view
//     frame_tick       one-cycle pulse, once per frame
//     ship_en, alien_en, proj_en, fire_en   per-frame update strobes
//     field_clr, shots_clr                  one-cycle clear pulses
//     lives, level     game status
//
//   Handshake rule: there is no valid/ready pair. Every strobe and clear is
//   a single-cycle, fire-and-forget pulse. A consumer acts on it in the cycle
//   it is high and cannot stall it. Event inputs are sampled every cycle with
//   no acknowledge; a pulse that arrives while it is ignored is simply lost.
//
//   Modports: master = sequencer side, slave = datapath side.
interface spinv_game_sequencer_if;
  logic       start;
  logic       player_hit;
  logic       wave_cleared;
  logic       invaders_landed;
  logic [2:0] state;
  logic       frame_tick;
  logic       ship_en;
  logic       alien_en;
  logic       proj_en;
  logic       fire_en;
  logic       field_clr;
  logic       shots_clr;
  logic [1:0] lives;
  logic [3:0] level;

  modport master (
    input  start, player_hit, wave_cleared, invaders_landed,
    output state, frame_tick, ship_en, alien_en, proj_en, fire_en,
           field_clr, shots_clr, lives, level
  );

  modport slave (
    output start, player_hit, wave_cleared, invaders_landed,
    input  state, frame_tick, ship_en, alien_en, proj_en, fire_en,
           field_clr, shots_clr, lives, level
  );
endinterface

// File: rtl/spinv_game_sequencer.sv
// spinv_game_sequencer
//   Game-phase controller for the Space Invaders datapath. It runs the phase
//   FSM (IDLE, START banner, PLAY, HIT pause, CLEARED, OVER), tracks lives
//   and level, divides Clk down to a frame tick, and issues the per-frame
//   update strobes and the field and shot clear pulses.
//
//   Ports:
//     Clk    system clock
//     reset  synchronous, active-high
//     bus    spinv_game_sequencer_if.master (events in, strobes and status out)
//
//   The FSM state is driven straight onto bus.state, which is the debug view.
module spinv_game_sequencer #(
  parameter int FRAME_DIV      = 1666667,
  parameter int ALIEN_DIV_INIT = 4,
  parameter int ALIEN_DIV_MIN  = 1,
  parameter int BANNER_FRAMES  = 120,
  parameter int LIVES          = 3
) (
  input  logic                          Clk,
  input  logic                          reset,
  spinv_game_sequencer_if.master        bus
);

  localparam int FW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int BW = (BANNER_FRAMES > 1) ? $clog2(BANNER_FRAMES) : 1;
  localparam int AW = 8;

  localparam logic [FW-1:0] FRAME_LAST  = FW'(FRAME_DIV - 1);
  localparam logic [BW-1:0] BANNER_LAST = BW'(BANNER_FRAMES - 1);
  localparam logic [1:0]    LIVES_INIT  = 2'(LIVES);
  localparam logic [3:0]    LEVEL_MAX   = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_PLAY    = 3'd2,
    S_HIT     = 3'd3,
    S_CLEARED = 3'd4,
    S_OVER    = 3'd5
  } state_t;

  state_t        state_q;
  logic [FW-1:0] fcnt_q;
  logic [BW-1:0] bcnt_q;
  logic [AW-1:0] acnt_q;
  logic          parity_q;
  logic          start_q;
  logic [1:0]    lives_q;
  logic [3:0]    level_q;
  logic          field_clr_q;
  logic          shots_clr_q;

  logic          frame_tick;
  logic          start_evt;
  logic          banner_done;
  logic          in_play;
  logic [AW-1:0] adiv;
  logic          alien_last;
  int            lvl_m1;

  // ---------------------------------------------------------------------------
  // Frame divider: free-running in every state, including IDLE and OVER.
  // ---------------------------------------------------------------------------
  assign frame_tick = (fcnt_q == FRAME_LAST);

  always_ff @(posedge Clk) begin
    if (reset) begin
      fcnt_q <= '0;
    end else if (frame_tick) begin
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_q + 1'b1;
    end
  end

  // Start edge detector. start_q resets high so that a button held down
  // through reset release is not seen as a fresh press.
  always_ff @(posedge Clk) begin
    if (reset) begin
      start_q <= 1'b1;
    end else begin
      start_q <= bus.start;
    end
  end

  assign start_evt   = bus.start & ~start_q;
  assign banner_done = frame_tick & (bcnt_q == BANNER_LAST);
  assign in_play     = (state_q == S_PLAY);

  // Alien step divider: one frame faster per level, never below the minimum.
  // Done in signed int arithmetic so a high level cannot wrap the result to
  // a huge divider.
  always_comb begin
    lvl_m1 = int'(level_q) - 1;
    if ((ALIEN_DIV_INIT - lvl_m1) > ALIEN_DIV_MIN) begin
      adiv = AW'(ALIEN_DIV_INIT - lvl_m1);
    end else begin
      adiv = AW'(ALIEN_DIV_MIN);
    end
  end

  assign alien_last = (acnt_q == (adiv - 1'b1));

  // ---------------------------------------------------------------------------
  // Phase FSM with its banner/alien/parity counters, lives, level and the
  // registered clear pulses. Clears are raised on the edge that enters
  // START or HIT, so they are high exactly for the first cycle there and can
  // never overlap a PLAY-only enable.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      bcnt_q      <= '0;
      acnt_q      <= '0;
      parity_q    <= 1'b0;
      lives_q     <= LIVES_INIT;
      level_q     <= 4'd1;
      field_clr_q <= 1'b0;
      shots_clr_q <= 1'b0;
    end else begin
      field_clr_q <= 1'b0;
      shots_clr_q <= 1'b0;

      // Default counter motion; entry assignments below override these.
      if (frame_tick) begin
        bcnt_q   <= bcnt_q + 1'b1;
        parity_q <= ~parity_q;
      end

      case (state_q)
        S_IDLE, S_OVER: begin
          if (start_evt) begin
            state_q     <= S_START;
            lives_q     <= LIVES_INIT;
            level_q     <= 4'd1;
            bcnt_q      <= '0;
            field_clr_q <= 1'b1;
          end
        end

        S_START, S_HIT: begin
          if (banner_done) begin
            state_q  <= S_PLAY;
            acnt_q   <= '0;
            parity_q <= 1'b0;
          end
        end

        S_PLAY: begin
          // Priority: landed > hit > cleared. A hit that loses to a landing
          // is dropped, not remembered.
          if (bus.invaders_landed) begin
            state_q <= S_OVER;
            lives_q <= 2'd0;
          end else if (bus.player_hit) begin
            if (lives_q <= 2'd1) begin
              state_q <= S_OVER;
              lives_q <= 2'd0;
            end else begin
              state_q     <= S_HIT;
              lives_q     <= lives_q - 2'd1;
              bcnt_q      <= '0;
              shots_clr_q <= 1'b1;
            end
          end else if (bus.wave_cleared) begin
            state_q <= S_CLEARED;
            bcnt_q  <= '0;
            if (level_q != LEVEL_MAX) begin
              level_q <= level_q + 4'd1;
            end
          end else if (frame_tick) begin
            acnt_q <= alien_last ? '0 : (acnt_q + 1'b1);
          end
        end

        S_CLEARED: begin
          if (banner_done) begin
            state_q     <= S_START;
            bcnt_q      <= '0;
            field_clr_q <= 1'b1;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. Enables are gated by the registered PLAY state, so they are
  // zero in every other phase.
  // ---------------------------------------------------------------------------
  assign bus.state      = state_q;
  assign bus.frame_tick = frame_tick;
  assign bus.ship_en    = in_play & frame_tick;
  assign bus.proj_en    = in_play & frame_tick;
  assign bus.fire_en    = in_play & frame_tick & ~parity_q;
  assign bus.alien_en   = in_play & frame_tick & alien_last;
  assign bus.field_clr  = field_clr_q;
  assign bus.shots_clr  = shots_clr_q;
  assign bus.lives      = lives_q;
  assign bus.level      = level_q;

endmodule
